// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester memory arbiter: FSM encodings,
// requester identifiers and the BUSY watchdog counter width.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_CPU = 1'b0;
   localparam req_id_t REQ_DMA = 1'b1;

   localparam int CNT_W = 8;

   // Read and write both high collapse to a read, so "pending" is just the OR.
   function automatic logic is_pending(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Two-way round-robin pick: a lone pending requester wins outright, a tie
// goes to whichever requester was not granted last.
module arb_rr_select
   import mem_arbiter_pkg::*;
(
   input  logic cpu_pend,
   input  logic dma_pend,
   input  logic last_grant,
   output logic winner,
   output logic any_pend
);

   always_comb begin
      winner   = REQ_CPU;
      any_pend = cpu_pend | dma_pend;
      if (cpu_pend && dma_pend) begin
         winner = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
      end else if (dma_pend) begin
         winner = REQ_DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between a CPU and a DMA requester with
// round-robin tie-breaking, registered strobes and a BUSY watchdog.
//
// Handshake: a requester holds read/write (plus addr/wdata) high until it sees
// its done pulse and drops the request in that done cycle; the memory answers
// a strobe with a one-cycle inputReady while the arbiter is BUSY.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int TIMEOUT   = 255
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_read,
   input  logic                 cpu_write,
   input  logic [WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   input  logic                 dma_read,
   input  logic                 dma_write,
   input  logic [WORD_SIZE-1:0] dma_addr,
   input  logic [WORD_SIZE-1:0] dma_wdata,
   output logic                 cpu_done,
   output logic                 dma_done,
   output logic                 cpu_grant,
   output logic                 dma_grant,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 err,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   input  logic                 inputReady,
   output logic [1:0]           state_dbg
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   busy_cnt_q;
   req_id_t            last_grant_q;
   req_id_t            owner_q;
   logic               op_read_q;

   req_id_t            winner;
   logic               any_pend;
   logic               sel_read;
   logic [WORD_SIZE-1:0] sel_addr;
   logic [WORD_SIZE-1:0] sel_wdata;
   logic               complete;
   logic               abort;
   logic               grant_now;

   logic                 readM_d, writeM_d;
   logic [WORD_SIZE-1:0] address_d, mem_wdata_d, rdata_d;
   logic                 cpu_grant_d, dma_grant_d;
   logic                 cpu_done_d, dma_done_d, err_d;

   assign state_dbg = state_q;

   arb_rr_select u_rr (
      .cpu_pend   (is_pending(cpu_read, cpu_write)),
      .dma_pend   (is_pending(dma_read, dma_write)),
      .last_grant (last_grant_q),
      .winner     (winner),
      .any_pend   (any_pend)
   );

   always_comb begin
      sel_read  = (winner == REQ_CPU) ? cpu_read  : dma_read;
      sel_addr  = (winner == REQ_CPU) ? cpu_addr  : dma_addr;
      sel_wdata = (winner == REQ_CPU) ? cpu_wdata : dma_wdata;
   end

   assign grant_now = (state_q == ST_IDLE) && any_pend;
   // inputReady in the final watchdog cycle wins over the abort.
   assign complete  = (state_q == ST_BUSY) && inputReady;
   assign abort     = (state_q == ST_BUSY) && !inputReady && (busy_cnt_q == TIMEOUT_LAST);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_pend)           state_d = ST_BUSY;
         ST_BUSY: if (complete || abort)  state_d = ST_RESP;
         ST_RESP:                         state_d = ST_IDLE;
         default:                         state_d = ST_IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs
   always_comb begin
      readM_d     = readM;
      writeM_d    = writeM;
      address_d   = address;
      mem_wdata_d = mem_wdata;
      rdata_d     = rdata;
      cpu_grant_d = cpu_grant;
      dma_grant_d = dma_grant;
      cpu_done_d  = 1'b0;
      dma_done_d  = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_pend) begin
               readM_d     = sel_read;
               writeM_d    = !sel_read;
               address_d   = sel_addr;
               mem_wdata_d = sel_wdata;
               cpu_grant_d = (winner == REQ_CPU);
               dma_grant_d = (winner == REQ_DMA);
            end
         end
         ST_BUSY: begin
            if (complete || abort) begin
               readM_d    = 1'b0;
               writeM_d   = 1'b0;
               cpu_done_d = (owner_q == REQ_CPU);
               dma_done_d = (owner_q == REQ_DMA);
               err_d      = abort;
               if (complete && op_read_q) begin
                  rdata_d = mem_rdata;
               end
            end
         end
         ST_RESP: begin
            cpu_grant_d = 1'b0;
            dma_grant_d = 1'b0;
         end
         default: begin
            readM_d     = 1'b0;
            writeM_d    = 1'b0;
            cpu_grant_d = 1'b0;
            dma_grant_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readM     <= 1'b0;
         writeM    <= 1'b0;
         address   <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         cpu_grant <= 1'b0;
         dma_grant <= 1'b0;
         cpu_done  <= 1'b0;
         dma_done  <= 1'b0;
         err       <= 1'b0;
      end else begin
         readM     <= readM_d;
         writeM    <= writeM_d;
         address   <= address_d;
         mem_wdata <= mem_wdata_d;
         rdata     <= rdata_d;
         cpu_grant <= cpu_grant_d;
         dma_grant <= dma_grant_d;
         cpu_done  <= cpu_done_d;
         dma_done  <= dma_done_d;
         err       <= err_d;
      end
   end

   // Owner/op are latched with every grant; last_grant tracks aborted ones too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= REQ_DMA;
         owner_q      <= REQ_CPU;
         op_read_q    <= 1'b0;
      end else if (grant_now) begin
         last_grant_q <= winner;
         owner_q      <= winner;
         op_read_q    <= sel_read;
      end
   end

   // Watchdog counter: zero outside BUSY, so it is clear on every BUSY entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_cnt_q <= '0;
      end else if (state_q == ST_BUSY) begin
         busy_cnt_q <= busy_cnt_q + 1'b1;
      end else begin
         busy_cnt_q <= '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single access, ties, round-robin order,
// watchdog abort and its boundary, async reset mid-access, stray inputReady.
module tb_mem_arbiter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_read, cpu_write, dma_read, dma_write;
   logic [W-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic         cpu_done, dma_done, cpu_grant, dma_grant, err;
   logic [W-1:0] rdata, address, mem_wdata, mem_rdata;
   logic         readM, writeM, inputReady;
   logic [1:0]   state_dbg;

   int n_assert = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_rdata;
   int           n_hi;

   mem_arbiter #(.WORD_SIZE(W), .TIMEOUT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_read   (cpu_read),
      .cpu_write  (cpu_write),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .dma_read   (dma_read),
      .dma_write  (dma_write),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .cpu_done   (cpu_done),
      .dma_done   (dma_done),
      .cpu_grant  (cpu_grant),
      .dma_grant  (dma_grant),
      .rdata      (rdata),
      .err        (err),
      .readM      (readM),
      .writeM     (writeM),
      .address    (address),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .inputReady (inputReady),
      .state_dbg  (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_read = 0; cpu_write = 0; dma_read = 0; dma_write = 0;
      cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
      mem_rdata = '0; inputReady = 0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      idle_inputs();
      apply_reset();

      // Reset state
      check("rst_state",  32'(state_dbg), 32'd0);
      check("rst_strobe", {30'd0, readM, writeM}, 32'd0);
      check("rst_grant",  {30'd0, cpu_grant, dma_grant}, 32'd0);
      check("rst_done",   {29'd0, cpu_done, dma_done, err}, 32'd0);
      check("rst_addr",   32'(address), 32'd0);
      check("rst_wdata",  32'(mem_wdata), 32'd0);
      check("rst_rdata",  32'(rdata), 32'd0);

      // CPU read 0x0040, ready in third BUSY cycle with 0xBEEF
      cpu_read = 1; cpu_addr = 16'h0040;
      tick();
      check("rd_busy1_readM", 32'(readM), 32'd1);
      check("rd_busy1_addr",  32'(address), 32'h0040);
      check("rd_busy1_grant", {30'd0, cpu_grant, dma_grant}, 32'd2);
      tick();
      check("rd_busy2_readM", 32'(readM), 32'd1);
      tick();
      check("rd_busy3_readM", 32'(readM), 32'd1);
      inputReady = 1; mem_rdata = 16'hBEEF;
      tick();
      exp_rdata = 16'hBEEF;
      check("rd_resp_readM", 32'(readM), 32'd0);
      check("rd_resp_done",  {30'd0, cpu_done, dma_done}, 32'd2);
      check("rd_resp_err",   32'(err), 32'd0);
      check("rd_resp_rdata", 32'(rdata), 32'(exp_rdata));
      check("rd_resp_state", 32'(state_dbg), 32'd2);
      cpu_read = 0; inputReady = 0; mem_rdata = '0;
      tick();
      check("rd_idle_done",  {30'd0, cpu_done, dma_done}, 32'd0);
      check("rd_idle_grant", {30'd0, cpu_grant, dma_grant}, 32'd0);
      check("rd_idle_state", 32'(state_dbg), 32'd0);

      // Stray inputReady in IDLE
      inputReady = 1; mem_rdata = 16'h5555;
      tick();
      inputReady = 0;
      check("stray_done",  {29'd0, cpu_done, dma_done, err}, 32'd0);
      check("stray_rdata", 32'(rdata), 32'(exp_rdata));
      check("stray_state", 32'(state_dbg), 32'd0);
      tick();
      check("stray_rdata2", 32'(rdata), 32'(exp_rdata));

      // Tie straight after reset: CPU first, DMA follows without reasserting
      apply_reset();
      exp_rdata = '0;
      cpu_read = 1; cpu_addr = 16'h0100;
      dma_write = 1; dma_addr = 16'h0200; dma_wdata = 16'hAAAA;
      tick();
      check("tie_cpu_grant", {30'd0, cpu_grant, dma_grant}, 32'd2);
      check("tie_cpu_addr",  32'(address), 32'h0100);
      check("tie_cpu_readM", {30'd0, readM, writeM}, 32'd2);
      inputReady = 1; mem_rdata = 16'h1111;
      tick();
      exp_rdata = 16'h1111;
      check("tie_cpu_done", {30'd0, cpu_done, dma_done}, 32'd2);
      check("tie_cpu_rdata", 32'(rdata), 32'(exp_rdata));
      check("tie_cpu_grant_resp", {30'd0, cpu_grant, dma_grant}, 32'd2);
      cpu_read = 0; inputReady = 0;
      tick();
      check("tie_gap_grant", {30'd0, cpu_grant, dma_grant}, 32'd0);
      tick();
      check("tie_dma_grant", {30'd0, cpu_grant, dma_grant}, 32'd1);
      check("tie_dma_strobe", {30'd0, readM, writeM}, 32'd1);
      check("tie_dma_addr",  32'(address), 32'h0200);
      check("tie_dma_wdata", 32'(mem_wdata), 32'hAAAA);
      inputReady = 1; mem_rdata = 16'h7777;
      tick();
      check("tie_dma_done",  {29'd0, cpu_done, dma_done, err}, 32'd2);
      check("tie_dma_rdata", 32'(rdata), 32'(exp_rdata));
      dma_write = 0; inputReady = 0;
      tick();

      // Both requesting continuously: CPU, DMA, CPU, DMA
      cpu_write = 1; cpu_addr = 16'h0A00; cpu_wdata = 16'hC0DE;
      dma_read  = 1; dma_addr = 16'h0B00;
      for (int k = 0; k < 4; k++) begin
         logic dma_turn;
         dma_turn = (k % 2 == 1);
         tick();
         check($sformatf("rr%0d_grant", k), {30'd0, cpu_grant, dma_grant},
               dma_turn ? 32'd1 : 32'd2);
         check($sformatf("rr%0d_strobe", k), {30'd0, readM, writeM},
               dma_turn ? 32'd2 : 32'd1);
         inputReady = 1; mem_rdata = 16'h2000 + 16'(k);
         tick();
         if (dma_turn) exp_rdata = 16'h2000 + 16'(k);
         check($sformatf("rr%0d_done", k), {30'd0, cpu_done, dma_done},
               dma_turn ? 32'd1 : 32'd2);
         check($sformatf("rr%0d_rdata", k), 32'(rdata), 32'(exp_rdata));
         inputReady = 0;
         tick();
         check($sformatf("rr%0d_idle", k), 32'(state_dbg), 32'd0);
      end
      cpu_write = 0; dma_read = 0;
      tick();
      check("rr_quiet", 32'(state_dbg), 32'd0);

      // DMA write with no inputReady: watchdog abort after 255 BUSY cycles
      dma_write = 1; dma_addr = 16'h00FF; dma_wdata = 16'h1234;
      tick();
      check("to_addr",  32'(address), 32'h00FF);
      check("to_wdata", 32'(mem_wdata), 32'h1234);
      n_hi = 0;
      while (writeM === 1'b1 && n_hi < 300) begin
         n_hi++;
         tick();
      end
      check("to_writeM_cycles", 32'(n_hi), 32'd255);
      check("to_done_err", {29'd0, cpu_done, dma_done, err}, 32'd3);
      check("to_rdata",    32'(rdata), 32'(exp_rdata));
      dma_write = 0;
      tick();
      check("to_after", {29'd0, cpu_done, dma_done, err}, 32'd0);
      check("to_idle",  32'(state_dbg), 32'd0);

      // inputReady exactly in the timeout cycle completes normally
      dma_read = 1; dma_addr = 16'h0055;
      tick();
      repeat (254) tick();
      check("tb_edge_readM", 32'(readM), 32'd1);
      inputReady = 1; mem_rdata = 16'h9ABC;
      tick();
      exp_rdata = 16'h9ABC;
      check("tb_edge_done", {29'd0, cpu_done, dma_done, err}, 32'd2);
      check("tb_edge_rdata", 32'(rdata), 32'(exp_rdata));
      dma_read = 0; inputReady = 0;
      tick();

      // Async reset in second BUSY cycle of a CPU read (read+write = read)
      cpu_read = 1; cpu_write = 1; cpu_addr = 16'h0033;
      tick();
      check("rb_busy1_strobe", {30'd0, readM, writeM}, 32'd2);
      tick();
      check("rb_busy2_readM", 32'(readM), 32'd1);
      reset = 1'b1;
      #1;
      check("rb_async_readM", 32'(readM), 32'd0);
      check("rb_async_state", 32'(state_dbg), 32'd0);
      check("rb_async_grant", {30'd0, cpu_grant, dma_grant}, 32'd0);
      cpu_read = 0; cpu_write = 0;
      tick();
      reset = 1'b0;
      check("rb_no_done", {29'd0, cpu_done, dma_done, err}, 32'd0);
      tick();
      check("rb_still_no_done", {29'd0, cpu_done, dma_done, err}, 32'd0);
      cpu_read = 1; cpu_addr = 16'h0077;
      tick();
      check("rb_next_grant", {30'd0, cpu_grant, dma_grant}, 32'd2);
      check("rb_next_addr",  32'(address), 32'h0077);
      inputReady = 1; mem_rdata = 16'h4242;
      tick();
      check("rb_next_done",  {29'd0, cpu_done, dma_done, err}, 32'd4);
      check("rb_next_rdata", 32'(rdata), 32'h4242);
      cpu_read = 0; inputReady = 0;
      tick();
      check("rb_next_idle", 32'(state_dbg), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Grants must never be both high
   always @(negedge clk) begin
      if (cpu_grant === 1'b1 && dma_grant === 1'b1) begin
         n_assert++;
         n_fail++;
         $error("FAIL grant_overlap observed=11 expected=one-hot or zero");
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max BUSY cycles before abort (8-bit counter, 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports cpu_read, cpu_write  input  1 each  CPU access request levels.
REQ-006 SHALL have ports cpu_addr, cpu_wdata  input  WORD_SIZE each  CPU address and write data.
REQ-007 SHALL have ports dma_read, dma_write, dma_addr, dma_wdata  input  1/1/WORD_SIZE/WORD_SIZE  DMA request set, same meaning as the CPU set.
REQ-008 SHALL have ports cpu_done, dma_done  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports cpu_grant, dma_grant  output  1 each  owner indication, one-hot or zero.
REQ-010 SHALL have port rdata  output  WORD_SIZE  captured read data, held until next read capture.
REQ-011 SHALL have port err  output  1  pulse with done on timeout abort.
REQ-012 SHALL have ports readM, writeM, address, mem_wdata  output  1/1/WORD_SIZE/WORD_SIZE  memory-side strobes, address and write data.
REQ-013 SHALL have ports mem_rdata, inputReady  input  WORD_SIZE/1  memory read data and completion.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-015 IDLE: a requester is pending if its read or write is high; read and write both high SHALL be treated as a read.
REQ-016 Single pending requester SHALL be granted; if both are pending, grant SHALL go to the requester not granted last (last_grant register).
REQ-017 On grant, the arbiter SHALL latch address, wdata, op and owner, then enter BUSY.
REQ-018 Request seen in IDLE at cycle N: readM/writeM, address and the grant output SHALL be registered high from cycle N+1.
REQ-019 BUSY: strobes SHALL be held stable and new requests ignored; the idle requester SHALL keep waiting, with no loss of its request.
REQ-020 inputReady high in BUSY at cycle M:
  - read: rdata SHALL capture mem_rdata.
  - From M+1: strobes low, owner's done high for 1 cycle, state RESP.
REQ-021 RESP SHALL last exactly 1 cycle, then IDLE; grant SHALL drop on leaving RESP.
REQ-022 Minimum turnaround SHALL be 4 cycles per access (IDLE, BUSY, RESP, IDLE).
REQ-023 Requester SHALL deassert its request in the done cycle; a request still high in IDLE SHALL count as a new access.
REQ-024 inputReady outside BUSY SHALL be ignored.
REQ-025 BUSY counter SHALL clear on BUSY entry.
REQ-026 Counter reaching TIMEOUT without inputReady: strobes drop, done and err pulse together, rdata unchanged, RESP.
REQ-027 inputReady arriving in the timeout cycle SHALL win: normal completion, no err.
REQ-028 last_grant SHALL update on every grant, including aborted accesses.

Reset
REQ-029 reset high SHALL immediately force state IDLE and counter 0.
REQ-030 Outputs SHALL reset to: strobes, grants, done, err = 0; address, mem_wdata, rdata = 0.
REQ-031 last_grant SHALL reset to DMA so CPU wins the first tie.
REQ-032 Reset mid-BUSY SHALL abort silently: no done, no err.

Structure
REQ-033 State encodings and requester IDs SHALL live in the shared constants package.
REQ-034 Round-robin choice SHALL be one sub-module, arb_rr_select: inputs two pending bits plus last_grant, output the winner; purely combinational.

Verification
REQ-035 CPU read 0x0040, memory ready after 3 cycles with 0xBEEF -> readM high 3 cycles, cpu_done 1 pulse, rdata=0xBEEF, dma_done never.
REQ-036 CPU and DMA request same cycle after reset -> CPU served first, then DMA without reasserting; grants never overlap.
REQ-037 Both requesting continuously for 4 accesses -> grant order CPU, DMA, CPU, DMA.
REQ-038 DMA write 0x1234 to 0x00FF, inputReady never -> writeM high 255 cycles, then dma_done and err pulse together.
REQ-039 Reset asserted in second BUSY cycle of a CPU read -> readM low same cycle, no cpu_done; next request served normally.
REQ-040 inputReady pulsed in IDLE -> no done, no rdata change.
